ram_dump_reader: RTL and testbench
==================================

// Module: ram_dump_reader
// PURPOSE
//   Read-side counterpart of the program loader. Walks a contiguous range of main memory
//   using the RAM's address/load/data ports and streams each word out on a valid/ready
//   port, tagged with its address. Used to dump results (e.g. R0..R15) after a program
//   run, and to read back a loaded program image for checking.
// PARAMETERS
//   ADDR_WIDTH    7   RAM address width; the memory holds 2^ADDR_WIDTH words
//   DATA_WIDTH    16  RAM word width
//   READ_LATENCY  1   cycles from driving ram_address to sampling ram_output; legal range 1..4
// PORTS
//   clock        in   1              system clock, rising edge
//   reset        in   1              synchronous, active-high
//   start        in   1              request a dump; sampled only in IDLE
//   base_addr    in   ADDR_WIDTH     first address to read
//   word_count   in   ADDR_WIDTH+1   number of words to read, 0..2^ADDR_WIDTH
//   busy         out  1              high while in WAIT or HOLD
//   done         out  1              one-cycle pulse when the dump finishes
//   ram_address  out  ADDR_WIDTH     address to the RAM
//   ram_load     out  1              RAM write enable; tied to 0
//   ram_output   in   DATA_WIDTH     RAM read data
//   out_valid    out  1              out_data/out_addr/out_last are valid
//   out_ready    in   1              consumer accepts the word
//   out_data     out  DATA_WIDTH     word read from the RAM
//   out_addr     out  ADDR_WIDTH     address of out_data
//   out_last     out  1              high with the final word of the dump
// BEHAVIOUR
//   Reset: state=IDLE. busy, done, ram_address, out_valid, out_data, out_addr and out_last are all 0.
//   Reset mid-dump: abort the dump; no done pulse; the block is back in IDLE on the next cycle.
//   IDLE:
//     - start=1, word_count>0: latch ptr=base_addr and remaining=min(word_count, 2^ADDR_WIDTH);
//       drive ram_address=base_addr; load lat=READ_LATENCY; go to WAIT.
//     - start=1, word_count=0: go to DONE (no data word is produced).
//   WAIT:
//     - Hold ram_address=ptr and decrement lat every cycle.
//     - At the edge where lat reaches 0: capture out_data=ram_output, out_addr=ptr,
//       out_last=(remaining==1); set out_valid=1; go to HOLD.
//   HOLD:
//     - out_valid, out_data, out_addr, out_last and ram_address stay stable until out_valid&out_ready.
//     - On that handshake with remaining==1: clear out_valid; go to DONE.
//     - Otherwise: ptr=(ptr+1) mod 2^ADDR_WIDTH; remaining-=1; ram_address=new ptr;
//       lat=READ_LATENCY; clear out_valid; go to WAIT.
//   DONE: done=1 for exactly one cycle, then go to IDLE. A new start is accepted on the cycle after DONE.
//   Timing:
//     - start sampled at edge k -> first out_valid high after edge k+READ_LATENCY.
//     - With out_ready held high, one word every READ_LATENCY+1 cycles.
//     - done is high for the cycle after the final handshake edge.
//   start while busy or in DONE: ignored; base_addr and word_count are not re-sampled.
//   Address wrap: 2^ADDR_WIDTH-1 -> 0, with no error.
//   word_count above 2^ADDR_WIDTH: saturated to 2^ADDR_WIDTH (every address read exactly once).
//   ram_load is 0 in every state, including during and after reset.
// TESTING
//   1. RAM[1]=5, RAM[2]=25; base=1, count=2, ready=1, LAT=1
//      -> (5,addr1,last0) then (25,addr2,last1); valid after edge k+1 and k+3; done one cycle later.
//   2. Same setup, out_ready low for 5 cycles while out_valid=1
//      -> out_data/out_addr/ram_address stable; no word skipped or duplicated.
//   3. base=126, count=4, RAM[126,127,0,1]=A,B,C,D
//      -> out_addr 126,127,0,1 with data A,B,C,D; out_last only on D.
//   4. count=0 with start -> done pulse on the next cycle; out_valid never asserted; busy stays 0.
//   5. base=0, count=8; assert reset after 2 handshakes
//      -> all outputs 0 on the next cycle; no done; a new start with base=3, count=1 returns RAM[3].
//   6. start pulsed while busy -> ignored; count=200 (ADDR_WIDTH=7) -> exactly 128 words, out_last on the 128th.

Source files
------------

// File: rtl/ram_dump_reader_if.sv
// Bundles the RAM read port and the valid/ready output stream of the dump reader.
// The master side is the reader; the slave side is the RAM plus the downstream consumer.
interface ram_dump_reader_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_load;
    logic [DATA_WIDTH-1:0] ram_output;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_last;

    modport master (
        output ram_address, ram_load,
        input  ram_output,
        output out_valid, out_data, out_addr, out_last,
        input  out_ready
    );

    modport slave (
        input  ram_address, ram_load,
        output ram_output,
        input  out_valid, out_data, out_addr, out_last,
        output out_ready
    );
endinterface

// File: rtl/ram_dump_reader.sv
// Walks a contiguous RAM range and streams each word out tagged with its address.
// Used to dump results or read back a loaded program image.
//
// state  | meaning
// IDLE   | waiting for start
// WAIT   | address driven, counting down the RAM read latency
// HOLD   | word presented on the stream, waiting for out_ready
// DONE   | one-cycle done pulse
module ram_dump_reader #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    ram_dump_reader_if.master     bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [2:0]          LAT_LOAD   = 3'(READ_LATENCY);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [2:0]            lat;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  last_q;
    logic [ADDR_WIDTH:0]   count_sat;
    logic                  lat_tc;
    logic                  last_word;

    assign count_sat = (word_count > FULL_COUNT) ? FULL_COUNT : word_count;
    assign lat_tc    = (lat == 3'd1);
    assign last_word = (remaining == (ADDR_WIDTH+1)'(1));

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = (word_count == '0) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (lat_tc) state_next = S_HOLD;
            end
            S_HOLD: begin
                if (bus.out_ready) state_next = last_word ? S_DONE : S_WAIT;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: lat is a down-counter; the capture happens on the edge it hits zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr       <= '0;
            remaining <= '0;
            lat       <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (word_count != '0)) begin
                        ptr       <= base_addr;
                        remaining <= count_sat;
                        lat       <= LAT_LOAD;
                    end
                end
                S_WAIT: begin
                    lat <= lat - 3'd1;
                    if (lat_tc) begin
                        data_q <= bus.ram_output;
                        addr_q <= ptr;
                        last_q <= last_word;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready && !last_word) begin
                        ptr       <= ptr + ADDR_WIDTH'(1);
                        remaining <= remaining - (ADDR_WIDTH+1)'(1);
                        lat       <= LAT_LOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy            = (state == S_WAIT) || (state == S_HOLD);
    assign done            = (state == S_DONE);
    assign bus.out_valid   = (state == S_HOLD);
    assign bus.out_data    = data_q;
    assign bus.out_addr    = addr_q;
    assign bus.out_last    = last_q;
    assign bus.ram_address = ptr;
    assign bus.ram_load    = 1'b0;
endmodule

// File: tb/tb_ram_dump_reader.sv
// Scoreboard bench for ram_dump_reader: a reference model queues expected words per dump,
// and a monitor pops/compares them on every accepted handshake.
module tb_ram_dump_reader;
    localparam int AW = 7;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          last;
    } word_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] mem [DEPTH];

    ram_dump_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .bus        (bus.master)
    );

    // Read latency 1: data for the driven address is present by the next edge.
    assign bus.ram_output = mem[bus.ram_address];

    always #5 clock = ~clock;

    word_t sb_q[$];
    int    exp_done = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    acc_cnt = 0;
    bit    rand_ready = 1'b0;
    bit    ready_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the words a dump of (b, c) must yield, in order.
    task automatic push_dump(input int b, input int c);
        int n;
        n = (c > DEPTH) ? DEPTH : c;
        for (int i = 0; i < n; i++) begin
            word_t w;
            int a;
            a = (b + i) % DEPTH;
            w.data = mem[a];
            w.addr = AW'(a);
            w.last = (i == n - 1);
            sb_q.push_back(w);
        end
        exp_done++;
    endtask

    // Caller is at posedge+2; returns at the edge that sampled start, +2.
    task automatic issue(input int b, input int c);
        base_addr  = AW'(b);
        word_count = (AW+1)'(c);
        start      = 1'b1;
        push_dump(b, c);
        @(posedge clock); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            if (done) break;
            @(posedge clock); #2;
        end
        check({name, "_done_seen"}, 64'(k < limit), 64'd1);
        @(posedge clock); #2;
        check({name, "_idle_busy"}, 64'(busy), 64'd0);
        check({name, "_idle_done"}, 64'(done), 64'd0);
    endtask

    // Monitor: drives out_ready and checks every accepted word and every done pulse.
    always @(negedge clock) begin
        word_t e;
        word_t got;
        bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        check("ram_load_zero", 64'(bus.ram_load), 64'd0);
        if (bus.out_valid && bus.out_ready) begin
            got = '{data: bus.out_data, addr: bus.out_addr, last: bus.out_last};
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got addr %0d data 0x%0h, expected no word", bus.out_addr, bus.out_data);
            end else begin
                e = sb_q.pop_front();
                check("word_data_addr_last", 64'(got), 64'(e));
            end
            acc_cnt++;
        end
        if (done) begin
            check("done_expected", 64'(exp_done > 0), 64'd1);
            check("done_all_words_seen", 64'(sb_q.size()), 64'd0);
            if (exp_done > 0) exp_done--;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int b;
        int c;
        int acc0;
        logic [DW-1:0] d0;
        logic [AW-1:0] a0;
        logic [AW-1:0] r0;

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        mem[1] = 16'd5;
        mem[2] = 16'd25;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clock);
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_ram_address", 64'(bus.ram_address), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_addr", 64'(bus.out_addr), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        reset = 1'b0;
        @(posedge clock); #2;

        // 1: two words, ready high, cycle-exact timing
        rand_ready = 1'b0; ready_force = 1'b1;
        @(posedge clock); #2;
        issue(1, 2);
        check("t1_busy_k", 64'(busy), 64'd1);
        check("t1_valid_k", 64'(bus.out_valid), 64'd0);
        check("t1_ram_address_k", 64'(bus.ram_address), 64'd1);
        @(posedge clock); #2;
        check("t1_valid_k1", 64'(bus.out_valid), 64'd1);
        check("t1_data0", 64'(bus.out_data), 64'd5);
        check("t1_last0", 64'(bus.out_last), 64'd0);
        @(posedge clock); #2;
        check("t1_valid_k2", 64'(bus.out_valid), 64'd0);
        @(posedge clock); #2;
        check("t1_valid_k3", 64'(bus.out_valid), 64'd1);
        check("t1_data1", 64'(bus.out_data), 64'd25);
        check("t1_addr1", 64'(bus.out_addr), 64'd2);
        check("t1_last1", 64'(bus.out_last), 64'd1);
        @(posedge clock); #2;
        check("t1_done_k4", 64'(done), 64'd1);
        check("t1_busy_k4", 64'(busy), 64'd0);
        @(posedge clock); #2;
        check("t1_done_k5", 64'(done), 64'd0);

        // 2: backpressure, output held stable
        ready_force = 1'b0;
        @(posedge clock); #2;
        issue(1, 2);
        for (k = 0; k < 20 && !bus.out_valid; k++) begin
            @(posedge clock); #2;
        end
        check("t2_valid_seen", 64'(bus.out_valid), 64'd1);
        d0 = bus.out_data; a0 = bus.out_addr; r0 = bus.ram_address;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #2;
            check("t2_hold_valid", 64'(bus.out_valid), 64'd1);
            check("t2_hold_data", 64'(bus.out_data), 64'(d0));
            check("t2_hold_addr", 64'(bus.out_addr), 64'(a0));
            check("t2_hold_ram_address", 64'(bus.ram_address), 64'(r0));
        end
        ready_force = 1'b1;
        wait_done("t2", 50);

        // 3: address wrap
        mem[126] = 16'hAAAA; mem[127] = 16'hBBBB; mem[0] = 16'hCCCC; mem[1] = 16'hDDDD;
        rand_ready = 1'b1;
        issue(126, 4);
        wait_done("t3", 100);

        // 4: zero count
        issue(0, 0);
        check("t4_done", 64'(done), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_valid", 64'(bus.out_valid), 64'd0);
        wait_done("t4", 5);

        // 5: reset after two handshakes
        issue(0, 8);
        acc0 = acc_cnt;
        for (k = 0; k < 200 && acc_cnt < acc0 + 2; k++) begin
            @(posedge clock); #2;
        end
        check("t5_two_handshakes", 64'(acc_cnt - acc0), 64'd2);
        reset = 1'b1;
        @(posedge clock); #2;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_valid", 64'(bus.out_valid), 64'd0);
        check("t5_ram_address", 64'(bus.ram_address), 64'd0);
        check("t5_out_data", 64'(bus.out_data), 64'd0);
        check("t5_out_addr", 64'(bus.out_addr), 64'd0);
        check("t5_out_last", 64'(bus.out_last), 64'd0);
        reset = 1'b0;
        sb_q.delete();
        exp_done = 0;
        issue(3, 1);
        wait_done("t5", 50);

        // 6: saturated count with a start pulse while busy
        b = $urandom_range(0, DEPTH - 1);
        acc0 = acc_cnt;
        issue(b, 200);
        repeat (3) @(posedge clock);
        #2;
        base_addr = AW'(5); word_count = (AW+1)'(3); start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
        wait_done("t6", 3000);
        check("t6_word_count", 64'(acc_cnt - acc0), 64'(DEPTH));

        // Random dumps
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            b = $urandom_range(0, DEPTH - 1);
            c = $urandom_range(0, 20);
            issue(b, c);
            wait_done("rand", 400);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
